// File: rtl/mem_access_unit_if.sv
// Load/store bus between the OTTER datapath, mem_access_unit and the byte-enabled BRAM.
// The slave modport is the access unit; master is the CPU side plus the BRAM it fronts.
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int BUS_WIDTH  = 32
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [BUS_WIDTH-1:0]  req_addr;
    logic [BUS_WIDTH-1:0]  req_wdata;
    logic                  resp_valid;
    logic [BUS_WIDTH-1:0]  resp_rdata;
    logic                  resp_misaligned;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_we;
    logic [BUS_WIDTH-1:0]  mem_wdata;
    logic [BUS_WIDTH-1:0]  mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front end: byte/half/word requests to a single-port byte-enabled BRAM,
// hiding the one-cycle read latency and returning extended load data with a done pulse.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 13,
    parameter int BUS_WIDTH  = 32
) (
    input logic             clk,
    input logic             rst_n,
    mem_access_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_WAIT = 2'b01,
        RESP    = 2'b10
    } state_t;

    state_t state_r, state_s;

    logic                 accept_s;
    logic                 mis_s;
    logic [3:0]           mem_we_s;
    logic [1:0]           off_r;
    logic [1:0]           size_r;
    logic                 uns_r;
    logic                 ready_r;
    logic                 resp_valid_r;
    logic                 resp_mis_r;
    logic [BUS_WIDTH-1:0] resp_rdata_r;
    logic                 unused_addr_s;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = off[0];
            2'b10:   bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_we(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] we;
        we = 4'b0000;
        case (size)
            2'b00:   we = 4'b0001 << off;
            2'b01:   we = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   we = 4'b1111;
            default: we = 4'b0000;
        endcase
        return we;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        d = wdata;
        case (size)
            2'b00:   d = {4{wdata[7:0]}};
            2'b01:   d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] off,
                                                 input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'b00:   b = rdata[7:0];
            2'b01:   b = rdata[15:8];
            2'b10:   b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    // Next-state decode; lane enables only in an accepted, aligned store while out of reset
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        mem_we_s = 4'b0000;
        mis_s    = is_misaligned(bus.req_size, bus.req_addr[1:0]);
        case (state_r)
            IDLE: begin
                if (bus.req_valid && rst_n) begin
                    accept_s = 1'b1;
                    if (mis_s) begin
                        state_s = RESP;
                    end else if (bus.req_we) begin
                        mem_we_s = lane_we(bus.req_size, bus.req_addr[1:0]);
                        state_s  = RESP;
                    end else begin
                        state_s = RD_WAIT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD_WAIT: state_s = RESP;
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, captured request fields and registered response outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            ready_r      <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_mis_r   <= 1'b0;
            resp_rdata_r <= {BUS_WIDTH{1'b0}};
            off_r        <= 2'b00;
            size_r       <= 2'b00;
            uns_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            ready_r      <= (state_s == IDLE);
            resp_valid_r <= (state_s == RESP);
            resp_mis_r   <= accept_s && mis_s;
            if (accept_s) begin
                off_r  <= bus.req_addr[1:0];
                size_r <= bus.req_size;
                uns_r  <= bus.req_unsigned;
            end
            // BRAM data for the captured address is present only while waiting in RD_WAIT
            if (state_r == RD_WAIT) begin
                resp_rdata_r <= load_extract(bus.mem_rdata, off_r, size_r, uns_r);
            end
        end
    end

    assign bus.req_ready       = ready_r;
    assign bus.resp_valid      = resp_valid_r;
    assign bus.resp_misaligned = resp_mis_r;
    assign bus.resp_rdata      = resp_rdata_r;
    assign bus.mem_addr        = bus.req_addr[ADDR_WIDTH+1:2];
    assign bus.mem_we          = mem_we_s;
    assign bus.mem_wdata       = lane_wdata(bus.req_size, bus.req_wdata);

    // Upper address bits fold away: accesses wrap modulo the BRAM size
    assign unused_addr_s = ^bus.req_addr[BUS_WIDTH-1:ADDR_WIDTH+2];

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural byte-enabled BRAM model.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] last_rd;

    mem_access_unit_if #(.ADDR_WIDTH(13), .BUS_WIDTH(32)) bus ();

    mem_access_unit #(.ADDR_WIDTH(13), .BUS_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_model [0:8191];

    // BRAM model: byte-lane writes, registered read; word 0x400 reloaded while in reset
    always @(posedge clk) begin
        if (!rst_n) begin
            mem_model[13'h400] <= 32'h00123456;
        end
        for (int i = 0; i < 4; i++) begin
            if (bus.mem_we[i]) mem_model[bus.mem_addr][i*8 +: 8] <= bus.mem_wdata[i*8 +: 8];
        end
        bus.mem_rdata <= mem_model[bus.mem_addr];
    end

    task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
    endtask

    task automatic idle_req();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        drive_req(1'b1, 2'b10, 1'b0, 32'h00001000, 32'hDEADBEEF);
        #1;
        checks++;
        if (bus.mem_we !== 4'b0000) begin errors++; $display("FAIL rst_mem_we got=%b exp=0000", bus.mem_we); end
        @(posedge clk); #1;
        checks++;
        if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got=%b exp=0", bus.resp_valid); end
        checks++;
        if (bus.resp_misaligned !== 1'b0) begin errors++; $display("FAIL rst_resp_mis got=%b exp=0", bus.resp_misaligned); end
        checks++;
        if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_rdata got=%h exp=00000000", bus.resp_rdata); end
        idle_req();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", bus.req_ready); end
    endtask

    task automatic test_byte_store();
        @(negedge clk);
        drive_req(1'b1, 2'b00, 1'b0, 32'h00001003, 32'h000000AB);
        #1;
        checks++;
        if (bus.mem_addr !== 13'h400) begin errors++; $display("FAIL st_addr got=%h exp=400", bus.mem_addr); end
        checks++;
        if (bus.mem_we !== 4'b1000) begin errors++; $display("FAIL st_we got=%b exp=1000", bus.mem_we); end
        checks++;
        if (bus.mem_wdata !== 32'hABABABAB) begin errors++; $display("FAIL st_wdata got=%h exp=ABABABAB", bus.mem_wdata); end
        @(posedge clk); #1;
        idle_req();
        checks++;
        if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL st_resp_valid got=%b exp=1", bus.resp_valid); end
        checks++;
        if (bus.resp_misaligned !== 1'b0) begin errors++; $display("FAIL st_resp_mis got=%b exp=0", bus.resp_misaligned); end
        checks++;
        if (bus.mem_we !== 4'b0000) begin errors++; $display("FAIL st_we_after got=%b exp=0000", bus.mem_we); end
        checks++;
        if (mem_model[13'h400] !== 32'hAB123456) begin errors++; $display("FAIL st_mem got=%h exp=AB123456", mem_model[13'h400]); end
        @(posedge clk); #1;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL st_done got valid=%b ready=%b exp valid=0 ready=1", bus.resp_valid, bus.req_ready);
        end
    endtask

    task automatic test_loads();
        logic [31:0] addrs [0:6] = '{32'h1003, 32'h1003, 32'h1001, 32'h1002, 32'h1000, 32'h1002, 32'h1000};
        logic [1:0]  sizes [0:6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10};
        logic        unss  [0:6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] exps  [0:6] = '{32'hFFFFFFAB, 32'h000000AB, 32'h00000034, 32'hFFFFAB12,
                                     32'h00003456, 32'h0000AB12, 32'hAB123456};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive_req(1'b0, sizes[i], unss[i], addrs[i], 32'hFFFFFFFF);
            #1;
            checks++;
            if (bus.mem_we !== 4'b0000 || bus.mem_addr !== 13'h400) begin
                errors++; $display("FAIL ld%0d_accept got we=%b addr=%h exp we=0000 addr=400", i, bus.mem_we, bus.mem_addr);
            end
            @(posedge clk); #1;
            idle_req();
            checks++;
            if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
                errors++; $display("FAIL ld%0d_wait got valid=%b ready=%b exp 0 0", i, bus.resp_valid, bus.req_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_misaligned !== 1'b0 || bus.resp_rdata !== exps[i]) begin
                errors++; $display("FAIL ld%0d_resp got valid=%b mis=%b rdata=%h exp 1 0 %h",
                                   i, bus.resp_valid, bus.resp_misaligned, bus.resp_rdata, exps[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL ld%0d_pulse got=%b exp=0", i, bus.resp_valid); end
        end
        last_rd = exps[6];
    endtask

    task automatic test_misaligned();
        logic        wes   [0:2] = '{1'b0, 1'b1, 1'b1};
        logic [1:0]  sizes [0:2] = '{2'b10, 2'b01, 2'b11};
        logic [31:0] addrs [0:2] = '{32'h1002, 32'h1001, 32'h1000};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_req(wes[i], sizes[i], 1'b0, addrs[i], 32'hFFFFFFFF);
            #1;
            checks++;
            if (bus.mem_we !== 4'b0000) begin errors++; $display("FAIL mis%0d_we got=%b exp=0000", i, bus.mem_we); end
            @(posedge clk); #1;
            idle_req();
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_misaligned !== 1'b1 || bus.resp_rdata !== last_rd) begin
                errors++; $display("FAIL mis%0d_resp got valid=%b mis=%b rdata=%h exp 1 1 %h",
                                   i, bus.resp_valid, bus.resp_misaligned, bus.resp_rdata, last_rd);
            end
            checks++;
            if (mem_model[13'h400] !== 32'hAB123456) begin errors++; $display("FAIL mis%0d_mem got=%h exp=AB123456", i, mem_model[13'h400]); end
            @(posedge clk); #1;
            checks++;
            if (bus.resp_valid !== 1'b0 || bus.resp_misaligned !== 1'b0) begin
                errors++; $display("FAIL mis%0d_clear got valid=%b mis=%b exp 0 0", i, bus.resp_valid, bus.resp_misaligned);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          acc [$];
        int          resp_cyc [$];
        logic [31:0] load_data;
        logic        rdy;
        int          phase;
        load_data = 32'h0;
        phase = 0;
        @(negedge clk);
        drive_req(1'b1, 2'b10, 1'b0, 32'h00002000, 32'h5A5AC3C3);
        for (int k = 0; k < 8; k++) begin
            rdy = bus.req_ready;
            if (bus.resp_valid === 1'b1) begin
                resp_cyc.push_back(k);
                load_data = bus.resp_rdata;
            end
            @(posedge clk); #1;
            if (rdy === 1'b1 && bus.req_valid === 1'b1) begin
                acc.push_back(k);
                if (phase == 0) drive_req(1'b0, 2'b10, 1'b0, 32'h00002000, 32'h0);
                else idle_req();
                phase++;
            end
            @(negedge clk);
        end
        checks++;
        if (acc.size() != 2 || acc[0] != 0 || acc[1] != 2) begin
            errors++; $display("FAIL b2b_accepts got n=%0d first=%0d second=%0d exp n=2 0 2",
                               acc.size(), (acc.size() > 0) ? acc[0] : -1, (acc.size() > 1) ? acc[1] : -1);
        end
        checks++;
        if (resp_cyc.size() != 2 || resp_cyc[0] != 1 || resp_cyc[1] != 4) begin
            errors++; $display("FAIL b2b_resp_cycles got n=%0d first=%0d second=%0d exp n=2 1 4",
                               resp_cyc.size(), (resp_cyc.size() > 0) ? resp_cyc[0] : -1, (resp_cyc.size() > 1) ? resp_cyc[1] : -1);
        end
        checks++;
        if (load_data !== 32'h5A5AC3C3) begin errors++; $display("FAIL b2b_rdata got=%h exp=5A5AC3C3", load_data); end
        checks++;
        if (mem_model[13'h800] !== 32'h5A5AC3C3) begin errors++; $display("FAIL b2b_mem got=%h exp=5A5AC3C3", mem_model[13'h800]); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive_req(1'b0, 2'b10, 1'b0, 32'h00001000, 32'h0);
        @(posedge clk); #1;
        idle_req();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", bus.resp_valid); end
        checks++;
        if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL rmid_rdata got=%h exp=00000000", bus.resp_rdata); end
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got=%b exp=1", bus.req_ready); end
        @(posedge clk); #1;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL rmid_after got valid=%b ready=%b exp 0 1", bus.resp_valid, bus.req_ready);
        end
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        last_rd          = 32'h0;
        repeat (2) @(posedge clk);
        test_reset();
        test_byte_store();
        test_loads();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front end between the multicycle OTTER control/datapath and the single-port byte-enabled block RAM.
- Accepts one byte/half/word request at a time and converts the byte address to a word address.
- Generates the 4-bit byte-lane write enable and lane-replicated write data.
- Absorbs the BRAM's one-cycle synchronous read latency and returns aligned, sign- or zero-extended load data with a done pulse.

Parameters:
- ADDR_WIDTH, 13, BRAM word-address width (8K x 32 words).
- BUS_WIDTH, 32, CPU data/address width; fixed at 32.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  input  1  loads only; 1 = zero-extend, 0 = sign-extend.
- req_addr  input  BUS_WIDTH  byte address.
- req_wdata  input  BUS_WIDTH  store data, right-justified.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  BUS_WIDTH  extended load result.
- resp_misaligned  output  1  qualifies resp_valid: request was rejected.
- mem_addr  output  ADDR_WIDTH  BRAM word address.
- mem_we  output  4  BRAM byte-lane write enables.
- mem_wdata  output  BUS_WIDTH  BRAM write data.
- mem_rdata  input  BUS_WIDTH  BRAM registered read data (valid one cycle after the address).

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset state:
  - state = IDLE.
  - resp_valid = 0, resp_misaligned = 0, resp_rdata = 0.
  - mem_we forced to 0000 in any cycle where rst_n = 0.
- States:
  - IDLE: req_ready = 1.
  - RD_WAIT: req_ready = 0.
  - RESP: req_ready = 0.
- Accept: req_valid & req_ready at edge N.
  - mem_addr = req_addr[ADDR_WIDTH+1:2], driven combinationally in cycle N.
  - Upper address bits are ignored, so addresses wrap modulo 4*2^ADDR_WIDTH.
  - Captured registers: addr[1:0], size, unsigned, we.
- Misaligned check:
  - Misaligned if size = 11, or half with addr[0] = 1, or word with addr[1:0] != 00.
  - Any misaligned request: mem_we = 0000 (no memory side effect).
  - Next state RESP with resp_misaligned = 1 and resp_rdata unchanged.
- Store path:
  - Byte: mem_we = 0001 << addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - Half: mem_we = 0011 (addr[1] = 0) or 1100 (addr[1] = 1); mem_wdata = {2{wdata[15:0]}}.
  - Word: mem_we = 1111; mem_wdata = wdata.
  - The write commits at edge N; next state RESP.
  - Store latency: resp_valid in cycle N+1.
- Load path:
  - mem_we = 0000 in cycle N; next state RD_WAIT.
  - In RD_WAIT (cycle N+1), mem_rdata is valid. Select the lane by captured addr[1:0] and size, extend per unsigned, register into resp_rdata.
  - Next state RESP.
  - Load latency: resp_valid in cycle N+2.
- RESP:
  - resp_valid = 1 for exactly one cycle, then IDLE.
  - resp_misaligned is 0 except on rejected requests.
- resp_rdata holds its value until the next successful load updates it.
- Outside the accept cycle, mem_we = 0000. mem_addr and mem_wdata are don't-care but must not toggle mem_we.
- No back-pressure on the response; the consumer must take resp_valid when it is pulsed.
- req_valid while not ready is ignored; the requester holds its request until req_ready.
- Back-to-back requests: a new request is accepted in the IDLE cycle immediately after RESP. Minimum spacing is 2 cycles per store and 3 per load.
- Reset mid-operation:
  - rst_n low in RD_WAIT or RESP aborts the transaction.
  - No resp_valid is produced for it; state returns to IDLE the following cycle.

Test Plan:
- Byte store: rst_n released; store byte req_addr = 0x00001003, wdata = 0x000000AB → in the accept cycle mem_addr = 0x400, mem_we = 1000, mem_wdata = 0xABABABAB. resp_valid exactly 1 cycle later, resp_misaligned = 0.
- Byte loads: word 0x400 preloaded with 0xAB123456.
  - Signed byte load at 0x1003 → resp_rdata = 0xFFFFFFAB two cycles after accept.
  - Unsigned byte load → 0x000000AB.
- Halfword loads, same word:
  - Signed half at 0x1002 → 0xFFFFAB12.
  - Unsigned half at 0x1000 → 0x00003456.
  - Word at 0x1000 → 0xAB123456.
- Misaligned requests: word load at 0x1002, half store at 0x1001, size = 11 → mem_we stays 0000 and memory is unchanged. resp_valid = resp_misaligned = 1 next cycle; resp_rdata retains its prior value.
- Back-to-back: store then load issued with req_valid held high throughout → accepts occur only while req_ready = 1, spaced 2 then 3 cycles. The load returns the just-stored data.
- Reset during RD_WAIT: rst_n low for 1 cycle → no resp_valid, resp_rdata = 0, req_ready = 1 the cycle after reset deasserts.
